// File: rtl/sub_serial32_pkg.sv
// Shared types and constants for the slice-serial 32-bit subtractor.
package sub_serial32_pkg;

    // Default geometry: 32-bit operands processed four bits per cycle.
    localparam int WIDTH_DEF = 32;
    localparam int SLICE_DEF = 4;

    // Counter width for n slices; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Derived constants for the default geometry.
    localparam int NSLICE = WIDTH_DEF / SLICE_DEF;
    localparam int CNT_W  = cnt_width(NSLICE);

    // Controller state encoding; also visible on the debug state port.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sub_serial32_sub4.sv
// Combinational W-bit borrow-lookahead subtractor slice: {bout, d} = x - y - bin.
// It mirrors the adder slice: generate a borrow where x=0,y=1, and pass an
// incoming borrow through bit positions where x==y.
module sub_serial32_sub4
    import sub_serial32_pkg::*;
#(
    parameter int W = SLICE_DEF
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         bin,
    output logic [W-1:0] d,
    output logic         bout
);

    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   bchain;
    logic         acc;
    logic         pp;

    // Flat lookahead: every borrow into bit i+1 is built directly from g/p
    // of bits i..0 and bin, with no ripple through earlier borrow terms.
    always_comb begin
        g      = ~x & y;
        p      = ~(x ^ y);
        bchain = '0;
        acc    = 1'b0;
        pp     = 1'b0;
        bchain[0] = bin;
        for (int i = 0; i < W; i++) begin
            acc = g[i];
            pp  = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (pp & g[j]);
                pp  = pp & p[j];
            end
            bchain[i+1] = acc | (pp & bin);
        end
        d    = x ^ y ^ bchain[W-1:0];
        bout = bchain[W];
    end

endmodule

// File: rtl/sub_serial32.sv
// Slice-serial subtractor: diff = a - b, one SLICE-bit slice per cycle with
// the borrow carried between cycles in a register.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is high only in IDLE; out_valid is high only in DONE,
// and diff/borrow/overflow/zero stay frozen until out_ready is seen there.
// A request raised while busy is simply not acknowledged and must be held.
module sub_serial32
    import sub_serial32_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SLICE = SLICE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow,
    output logic             zero,
    output logic [1:0]       state_dbg
);

    localparam int NS = WIDTH / SLICE;
    localparam int CW = cnt_width(NS);
    localparam logic [CW-1:0] LAST = CW'(NS - 1);

    state_t state_q;
    state_t state_d;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] diff_q;
    logic [WIDTH-1:0] diff_next;
    logic [CW-1:0]    cnt_q;
    logic             bin_q;
    logic             borrow_q;
    logic             overflow_q;
    logic             zero_q;

    logic [SLICE-1:0] x_slice;
    logic [SLICE-1:0] y_slice;
    logic [SLICE-1:0] d_slice;
    logic             bout;
    int               slice_base;

    // Select the current slice of the latched operands and splice its result
    // into the running difference.
    always_comb begin
        slice_base = int'(cnt_q) * SLICE;
        x_slice    = a_q[slice_base +: SLICE];
        y_slice    = b_q[slice_base +: SLICE];
        diff_next  = diff_q;
        diff_next[slice_base +: SLICE] = d_slice;
    end

    sub_serial32_sub4 #(
        .W (SLICE)
    ) u_slice (
        .x    (x_slice),
        .y    (y_slice),
        .bin  (bin_q),
        .d    (d_slice),
        .bout (bout)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: no accept in DONE even if out_ready is high.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (cnt_q == LAST) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake and debug outputs decoded from the current state.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        state_dbg = state_q;
    end

    // Datapath: latch operands on accept, process one slice per RUN cycle,
    // and capture the flags together with the final slice.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q        <= '0;
            b_q        <= '0;
            diff_q     <= '0;
            cnt_q      <= '0;
            bin_q      <= 1'b0;
            borrow_q   <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        cnt_q <= '0;
                        bin_q <= 1'b0;
                    end
                end
                RUN: begin
                    diff_q <= diff_next;
                    bin_q  <= bout;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        borrow_q   <= bout;
                        overflow_q <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                      (diff_next[WIDTH-1] != a_q[WIDTH-1]);
                        zero_q     <= (diff_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign diff     = diff_q;
    assign borrow   = borrow_q;
    assign overflow = overflow_q;
    assign zero     = zero_q;

endmodule
